// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the write-back arbiter, decoder and read muxes.
package regfile_pkg;

  localparam int REG_W     = 16;
  localparam int NREG      = 16;
  localparam int REG_IDX_W = 4;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  function automatic logic [NREG-1:0] onehot16(input reg_idx_t idx);
    logic [NREG-1:0] vec;
    vec = {{(NREG-1){1'b0}}, 1'b1} << idx;
    return vec;
  endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// One-entry skid holding an ALU result {dest, data} while load returns own the write port.
module wb_skid_buffer
  import regfile_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [DW+REG_IDX_W-1:0] data_i,
  input  logic                    hold_i,
  output logic                    full_o,
  output logic [DW+REG_IDX_W-1:0] data_o
);

  typedef enum logic {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } skid_state_t;

  skid_state_t                state_q, state_d;
  logic [DW+REG_IDX_W-1:0]    data_q, data_d;

  // State and payload registers; reset discards any held entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SKID_EMPTY;
      data_q  <= {(DW+REG_IDX_W){1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next state: capture only when an accepted beat collides with a load.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      SKID_EMPTY: begin
        if (valid_i && hold_i) begin
          state_d = SKID_FULL;
          data_d  = data_i;
        end else begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (hold_i) begin
          state_d = SKID_FULL;
        end else begin
          state_d = SKID_EMPTY;
        end
      end
      default: begin
        state_d = SKID_EMPTY;
      end
    endcase
  end

  // Outputs decoded straight from the state flop.
  always_comb begin
    ready_o = (state_q == SKID_EMPTY);
    full_o  = (state_q == SKID_FULL);
    data_o  = data_q;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU results and load returns into one registered one-hot register-bank write per
// cycle, and keeps the busy scoreboard of outstanding loads for the issue stage.
module writeback_arbiter
  import regfile_pkg::REG_IDX_W, regfile_pkg::reg_idx_t, regfile_pkg::onehot16;
#(
  parameter int DW   = 16,
  parameter int NREG = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_dest,
  input  logic [DW-1:0]        alu_data,
  input  logic                 ld_valid,
  input  logic [REG_IDX_W-1:0] ld_dest,
  input  logic [DW-1:0]        ld_data,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_dest,
  output logic [NREG-1:0]      busy,
  output logic [NREG-1:0]      rEnable,
  output logic [DW-1:0]        writePort,
  output logic [1:0]           err
);

  logic                    alu_fire_s;
  logic                    skid_full_s;
  logic [DW+REG_IDX_W-1:0] skid_data_s;
  logic                    wr_en_s;
  reg_idx_t                wr_dest_s;
  logic [DW-1:0]           wr_data_s;

  logic [NREG-1:0]         ren_q, ren_d;
  logic [DW-1:0]           wport_q, wport_d;
  logic [NREG-1:0]         busy_q, busy_d;
  logic [1:0]              err_q, err_d;

  wb_skid_buffer #(.DW(DW)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .valid_i (alu_valid),
    .ready_o (alu_ready),
    .data_i  ({alu_dest, alu_data}),
    .hold_i  (ld_valid),
    .full_o  (skid_full_s),
    .data_o  (skid_data_s)
  );

  assign alu_fire_s = alu_valid && alu_ready;

  // Write source priority: load, then held skid entry, then a fresh ALU handshake.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_dest_s = {REG_IDX_W{1'b0}};
    wr_data_s = {DW{1'b0}};
    if (ld_valid) begin
      wr_en_s   = 1'b1;
      wr_dest_s = ld_dest;
      wr_data_s = ld_data;
    end else if (skid_full_s) begin
      wr_en_s   = 1'b1;
      wr_dest_s = skid_data_s[DW+REG_IDX_W-1:DW];
      wr_data_s = skid_data_s[DW-1:0];
    end else if (alu_fire_s) begin
      wr_en_s   = 1'b1;
      wr_dest_s = alu_dest;
      wr_data_s = alu_data;
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  // Next values of the bank write, scoreboard and sticky error flags.
  always_comb begin
    ren_d   = {NREG{1'b0}};
    wport_d = wport_q;
    busy_d  = busy_q;
    err_d   = err_q;
    if (wr_en_s) begin
      ren_d   = onehot16(wr_dest_s);
      wport_d = wr_data_s;
    end else begin
      ren_d   = {NREG{1'b0}};
    end
    if (ld_valid) begin
      busy_d[ld_dest] = 1'b0;
      if (!busy_q[ld_dest]) begin
        err_d[0] = 1'b1;
      end else begin
        err_d[0] = err_q[0];
      end
    end else begin
      busy_d = busy_q;
    end
    // A load returning to the same register this cycle frees it, so a re-issue is legal.
    if (issue_valid) begin
      busy_d[issue_dest] = 1'b1;
      if (busy_q[issue_dest] && !(ld_valid && (ld_dest == issue_dest))) begin
        err_d[1] = 1'b1;
      end else begin
        err_d[1] = err_q[1];
      end
    end else begin
      err_d[1] = err_q[1];
    end
  end

  // Output, scoreboard and error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ren_q   <= {NREG{1'b0}};
      wport_q <= {DW{1'b0}};
      busy_q  <= {NREG{1'b0}};
      err_q   <= 2'b00;
    end else begin
      ren_q   <= ren_d;
      wport_q <= wport_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign rEnable   = ren_q;
  assign writePort = wport_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
